// File: rtl/box_update_arbiter.sv
// Bounding-box update arbiter: merges button and software box requests, validates
// them against the image and minimum size, and commits them only at frame start.
module box_update_arbiter #(
   parameter int unsigned IMAGE_WIDTH   = 1280,
   parameter int unsigned IMAGE_HEIGHT  = 720,
   parameter int unsigned MIN_BOX_SIZE  = 5,
   parameter int unsigned INIT_BOX_SIZE = 50,
   parameter int unsigned SW_PRIORITY   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic [15:0] btn_x1,
   input  logic [15:0] btn_x2,
   input  logic [15:0] btn_y1,
   input  logic [15:0] btn_y2,
   input  logic        sw_valid,
   output logic        sw_ready,
   input  logic [15:0] sw_x1,
   input  logic [15:0] sw_x2,
   input  logic [15:0] sw_y1,
   input  logic [15:0] sw_y2,
   input  logic        sw_lock,
   output logic [15:0] box_x1_o,
   output logic [15:0] box_x2_o,
   output logic [15:0] box_y1_o,
   output logic [15:0] box_y2_o,
   output logic        box_valid,
   output logic        owner_o,
   output logic [7:0]  reject_cnt,
   output logic        err_o
);

   localparam int unsigned CW = 16;
   localparam int unsigned RW = 8;
   localparam logic [CW-1:0] X_MAX    = CW'(IMAGE_WIDTH - 1);
   localparam logic [CW-1:0] Y_MAX    = CW'(IMAGE_HEIGHT - 1);
   localparam logic [CW-1:0] MIN_SPAN = CW'(MIN_BOX_SIZE - 1);
   localparam logic [CW-1:0] INIT_MAX = CW'(INIT_BOX_SIZE - 1);
   localparam logic [RW-1:0] RCNT_MAX = '1;
   localparam logic          SW_WINS  = (SW_PRIORITY != 0);

   typedef struct packed {
      logic [CW-1:0] x1;
      logic [CW-1:0] x2;
      logic [CW-1:0] y1;
      logic [CW-1:0] y2;
   } box_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_CHECK,
      S_WAIT_FRAME,
      S_COMMIT
   } state_t;

   state_t        state_q, state_d;
   box_t          btn_snap_q, btn_snap_d;
   logic          btn_pend_q, btn_pend_d;
   box_t          sw_buf_q, sw_buf_d;
   logic          sw_pend_q, sw_pend_d;
   box_t          cand_q, cand_d;
   logic          cand_sw_q, cand_sw_d;
   box_t          box_q, box_d;
   logic          box_valid_q, box_valid_d;
   logic          owner_q, owner_d;
   logic [RW-1:0] reject_cnt_q, reject_cnt_d;
   logic          err_q, err_d;
   logic          sw_ready_q, sw_ready_d;

   box_t btn_in_c;
   box_t sw_in_c;
   logic btn_changed_c;
   logic sw_fire_c;
   logic legal_c;

   always_comb begin
      btn_in_c      = '{x1: btn_x1, x2: btn_x2, y1: btn_y1, y2: btn_y2};
      sw_in_c       = '{x1: sw_x1, x2: sw_x2, y1: sw_y1, y2: sw_y2};
      btn_changed_c = (btn_in_c != btn_snap_q);
      sw_fire_c     = sw_valid & sw_ready_q;
   end

   // Ordering, image bounds and minimum span; x2 > x1 keeps the subtraction from wrapping.
   always_comb begin
      legal_c = (cand_q.x1 < cand_q.x2) && (cand_q.y1 < cand_q.y2) &&
                (cand_q.x2 <= X_MAX) && (cand_q.y2 <= Y_MAX) &&
                ((cand_q.x2 - cand_q.x1) >= MIN_SPAN) &&
                ((cand_q.y2 - cand_q.y1) >= MIN_SPAN);
   end

   always_comb begin
      state_d      = state_q;
      btn_snap_d   = btn_snap_q;
      btn_pend_d   = btn_pend_q;
      sw_buf_d     = sw_buf_q;
      sw_pend_d    = sw_pend_q;
      cand_d       = cand_q;
      cand_sw_d    = cand_sw_q;
      box_d        = box_q;
      box_valid_d  = 1'b0;
      owner_d      = owner_q;
      reject_cnt_d = reject_cnt_q;
      err_d        = 1'b0;
      sw_ready_d   = 1'b0;

      if (sw_fire_c) begin
         sw_buf_d  = sw_in_c;
         sw_pend_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (btn_pend_q || sw_pend_q || sw_fire_c) state_d = S_ARB;
         end
         S_ARB: begin
            if (sw_pend_q && (SW_WINS || !btn_pend_q)) begin
               cand_d    = sw_buf_q;
               cand_sw_d = 1'b1;
               sw_pend_d = 1'b0;
            end else begin
               cand_d     = btn_snap_q;
               cand_sw_d  = 1'b0;
               btn_pend_d = 1'b0;
            end
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (legal_c) begin
               state_d = S_WAIT_FRAME;
            end else begin
               err_d = 1'b1;
               if (reject_cnt_q != RCNT_MAX) reject_cnt_d = reject_cnt_q + RW'(1);
               state_d = S_IDLE;
            end
         end
         S_WAIT_FRAME: begin
            // Outputs are loaded here so they are visible during the COMMIT cycle.
            if (frame_start) begin
               box_d       = cand_q;
               owner_d     = cand_sw_q;
               box_valid_d = 1'b1;
               state_d     = S_COMMIT;
            end
         end
         S_COMMIT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A fresh button change wins over the clear issued by ARB in the same cycle.
      if (btn_changed_c) begin
         btn_snap_d = btn_in_c;
         if (!sw_lock) btn_pend_d = 1'b1;
      end

      sw_ready_d = (state_d == S_IDLE) && !sw_pend_d;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         btn_snap_q   <= btn_in_c;
         btn_pend_q   <= 1'b0;
         sw_buf_q     <= '0;
         sw_pend_q    <= 1'b0;
         cand_q       <= '0;
         cand_sw_q    <= 1'b0;
         box_q        <= '{x1: '0, x2: INIT_MAX, y1: '0, y2: INIT_MAX};
         box_valid_q  <= 1'b0;
         owner_q      <= 1'b0;
         reject_cnt_q <= '0;
         err_q        <= 1'b0;
         sw_ready_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         btn_snap_q   <= btn_snap_d;
         btn_pend_q   <= btn_pend_d;
         sw_buf_q     <= sw_buf_d;
         sw_pend_q    <= sw_pend_d;
         cand_q       <= cand_d;
         cand_sw_q    <= cand_sw_d;
         box_q        <= box_d;
         box_valid_q  <= box_valid_d;
         owner_q      <= owner_d;
         reject_cnt_q <= reject_cnt_d;
         err_q        <= err_d;
         sw_ready_q   <= sw_ready_d;
      end
   end

   assign box_x1_o   = box_q.x1;
   assign box_x2_o   = box_q.x2;
   assign box_y1_o   = box_q.y1;
   assign box_y2_o   = box_q.y2;
   assign box_valid  = box_valid_q;
   assign owner_o    = owner_q;
   assign reject_cnt = reject_cnt_q;
   assign err_o      = err_q;
   assign sw_ready   = sw_ready_q;

endmodule

// File: tb/tb_box_update_arbiter.sv
// Directed bench for box_update_arbiter: reset, commit timing, priority, rejection,
// bounds, lock and button coalescing with hand-computed expectations.
module tb_box_update_arbiter;

   logic        clk;
   logic        rst;
   logic        frame_start;
   logic [15:0] btn_x1, btn_x2, btn_y1, btn_y2;
   logic        sw_valid;
   logic        sw_ready;
   logic [15:0] sw_x1, sw_x2, sw_y1, sw_y2;
   logic        sw_lock;
   logic [15:0] box_x1_o, box_x2_o, box_y1_o, box_y2_o;
   logic        box_valid;
   logic        owner_o;
   logic [7:0]  reject_cnt;
   logic        err_o;

   int n_chk  = 0;
   int n_pass = 0;

   box_update_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .btn_x1      (btn_x1),
      .btn_x2      (btn_x2),
      .btn_y1      (btn_y1),
      .btn_y2      (btn_y2),
      .sw_valid    (sw_valid),
      .sw_ready    (sw_ready),
      .sw_x1       (sw_x1),
      .sw_x2       (sw_x2),
      .sw_y1       (sw_y1),
      .sw_y2       (sw_y2),
      .sw_lock     (sw_lock),
      .box_x1_o    (box_x1_o),
      .box_x2_o    (box_x2_o),
      .box_y1_o    (box_y1_o),
      .box_y2_o    (box_y2_o),
      .box_valid   (box_valid),
      .owner_o     (owner_o),
      .reject_cnt  (reject_cnt),
      .err_o       (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] box_of(input int x1, input int x2, input int y1, input int y2);
      return {16'(x1), 16'(x2), 16'(y1), 16'(y2)};
   endfunction

   function automatic logic [63:0] box_now();
      return {box_x1_o, box_x2_o, box_y1_o, box_y2_o};
   endfunction

   task automatic set_btn(input int x1, input int x2, input int y1, input int y2);
      btn_x1 = 16'(x1); btn_x2 = 16'(x2); btn_y1 = 16'(y1); btn_y2 = 16'(y2);
   endtask

   // Returns one cycle after the handshake edge (cycle T+1).
   task automatic sw_send(input int x1, input int x2, input int y1, input int y2);
      sw_x1 = 16'(x1); sw_x2 = 16'(x2); sw_y1 = 16'(y1); sw_y2 = 16'(y2);
      sw_valid = 1'b1;
      for (int i = 0; i < 20 && !sw_ready; i++) tick();
      check("sw_ready_wait", 64'(sw_ready), 64'd1);
      tick();
      sw_valid = 1'b0;
   endtask

   task automatic frame_pulse();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic frame_commit(input string tag);
      repeat (5) tick();
      frame_pulse();
      check(tag, 64'(box_valid), 64'd1);
   endtask

   initial begin
      rst = 1'b0; frame_start = 1'b0; sw_valid = 1'b0; sw_lock = 1'b0;
      sw_x1 = '0; sw_x2 = '0; sw_y1 = '0; sw_y2 = '0;
      set_btn(0, 49, 0, 49);
      repeat (3) tick();

      // Reset state
      check("rst_box", box_now(), box_of(0, 49, 0, 49));
      check("rst_owner", 64'(owner_o), 64'd0);
      check("rst_rcnt", 64'(reject_cnt), 64'd0);
      check("rst_ready", 64'(sw_ready), 64'd0);
      check("rst_valid", 64'(box_valid), 64'd0);
      rst = 1'b1;
      tick();
      check("ready_after_rst", 64'(sw_ready), 64'd1);

      // Software commit: early frame ignored, frame at T+5 -> pulse at T+6
      sw_send(100, 199, 50, 149);
      check("ready_drop", 64'(sw_ready), 64'd0);
      tick();
      frame_pulse();
      check("early_frame_valid", 64'(box_valid), 64'd0);
      check("early_frame_box", box_now(), box_of(0, 49, 0, 49));
      repeat (2) tick();
      frame_pulse();
      check("sw_commit_valid", 64'(box_valid), 64'd1);
      check("sw_commit_box", box_now(), box_of(100, 199, 50, 149));
      check("sw_commit_owner", 64'(owner_o), 64'd1);
      tick();
      check("valid_one_cycle", 64'(box_valid), 64'd0);
      check("ready_back", 64'(sw_ready), 64'd1);

      // Rejection of a 3-pixel-wide box
      sw_send(500, 502, 10, 100);
      repeat (2) tick();
      check("rej_err", 64'(err_o), 64'd1);
      check("rej_cnt1", 64'(reject_cnt), 64'd1);
      check("rej_box", box_now(), box_of(100, 199, 50, 149));
      check("rej_ready", 64'(sw_ready), 64'd1);
      tick();
      check("rej_err_pulse", 64'(err_o), 64'd0);

      // Saturation: 301 rejections total
      for (int i = 0; i < 300; i++) begin
         sw_send(500, 502, 10, 100);
         repeat (2) tick();
      end
      tick();
      check("rej_sat", 64'(reject_cnt), 64'd255);

      // Bounds: x2 = 1280 rejected, (1279,719) accepted
      sw_send(0, 1280, 0, 100);
      repeat (2) tick();
      check("bound_x2_err", 64'(err_o), 64'd1);
      check("rej_sat_hold", 64'(reject_cnt), 64'd255);
      tick();
      sw_send(1270, 1279, 710, 719);
      frame_commit("bound_max_valid");
      check("bound_max_box", box_now(), box_of(1270, 1279, 710, 719));
      repeat (2) tick();

      // Collision: software wins frame 1, button serviced on frame 2
      set_btn(10, 59, 0, 49);
      sw_send(300, 400, 300, 400);
      frame_commit("coll_f1_valid");
      check("coll_f1_box", box_now(), box_of(300, 400, 300, 400));
      check("coll_f1_owner", 64'(owner_o), 64'd1);
      frame_commit("coll_f2_valid");
      check("coll_f2_box", box_now(), box_of(10, 59, 0, 49));
      check("coll_f2_owner", 64'(owner_o), 64'd0);
      repeat (2) tick();

      // Lock: button change dropped
      sw_lock = 1'b1;
      set_btn(20, 69, 20, 69);
      repeat (6) tick();
      frame_pulse();
      check("lock_no_commit", 64'(box_valid), 64'd0);
      check("lock_box", box_now(), box_of(10, 59, 0, 49));
      sw_lock = 1'b0;
      repeat (2) tick();

      // Coalescing: three changes while busy with a rejected request -> one commit
      sw_send(500, 502, 10, 100);
      set_btn(30, 79, 30, 79);
      tick();
      set_btn(40, 89, 40, 89);
      tick();
      set_btn(60, 119, 60, 119);
      frame_commit("coal_valid");
      check("coal_box", box_now(), box_of(60, 119, 60, 119));
      check("coal_owner", 64'(owner_o), 64'd0);
      repeat (6) tick();
      frame_pulse();
      check("coal_single", 64'(box_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
